// File: rtl/fetch_decode.sv
// fetch_decode: RV32I-subset front end that owns the PC, fetches over a req/ack port and issues one decoded word at a time.
// Define FETCH_DECODE_COUNT_EN to add the retired_cnt / stall_cnt event counters.
module fetch_decode #(
   parameter int                 DATA_WIDTH = 32,
   parameter int                 NAME_BITS  = 5,
   parameter int                 CTRL_BITS  = 4,
   parameter int                 PC_BITS    = 16,
   parameter logic [PC_BITS-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [PC_BITS-1:0]    imem_addr,
   input  logic                  imem_ack,
   input  logic [31:0]           imem_rdata,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [PC_BITS-1:0]    redirect_pc,
   output logic                  valid,
   output logic [NAME_BITS-1:0]  rs1,
   output logic [NAME_BITS-1:0]  rs2,
   output logic [NAME_BITS-1:0]  ws,
   output logic [CTRL_BITS-1:0]  op,
   output logic                  imm_e,
   output logic [DATA_WIDTH-1:0] imm_d,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic                  illegal
`ifdef FETCH_DECODE_COUNT_EN
   ,
   output logic [31:0]           retired_cnt,
   output logic [31:0]           stall_cnt
`endif
);

   localparam logic [CTRL_BITS-1:0] ALU_AND = CTRL_BITS'(4'b0000);
   localparam logic [CTRL_BITS-1:0] ALU_ADD = CTRL_BITS'(4'b0001);
   localparam logic [CTRL_BITS-1:0] ALU_OR  = CTRL_BITS'(4'b0010);
   localparam logic [CTRL_BITS-1:0] ALU_XOR = CTRL_BITS'(4'b0011);
   localparam logic [CTRL_BITS-1:0] ALU_SUB = CTRL_BITS'(4'b0110);
   localparam logic [CTRL_BITS-1:0] ALU_SLT = CTRL_BITS'(4'b0111);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_ISSUE
   } state_t;

   state_t               state;
   logic [PC_BITS-1:0]   pc;
   logic                 discard;
   logic [PC_BITS-1:0]   redirect_target;

   logic [6:0]           opcode;
   logic [2:0]           funct3;
   logic [6:0]           funct7;
   logic [NAME_BITS-1:0] f_rs1;
   logic [NAME_BITS-1:0] f_rs2;
   logic [NAME_BITS-1:0] f_rd;
   logic [DATA_WIDTH-1:0] imm_i;
   logic [DATA_WIDTH-1:0] imm_s;

   logic [NAME_BITS-1:0]  d_rs1;
   logic [NAME_BITS-1:0]  d_rs2;
   logic [NAME_BITS-1:0]  d_ws;
   logic [CTRL_BITS-1:0]  d_op;
   logic                  d_imm_e;
   logic [DATA_WIDTH-1:0] d_imm_d;
   logic                  d_re;
   logic                  d_we;
   logic                  d_illegal;

   assign opcode = imem_rdata[6:0];
   assign funct3 = imem_rdata[14:12];
   assign funct7 = imem_rdata[31:25];
   assign f_rs1  = NAME_BITS'(imem_rdata[19:15]);
   assign f_rs2  = NAME_BITS'(imem_rdata[24:20]);
   assign f_rd   = NAME_BITS'(imem_rdata[11:7]);
   assign imm_i  = {{(DATA_WIDTH-12){imem_rdata[31]}}, imem_rdata[31:20]};
   assign imm_s  = {{(DATA_WIDTH-12){imem_rdata[31]}}, imem_rdata[31:25], imem_rdata[11:7]};

   // Redirect targets are word aligned; the low two bits are simply masked off.
   assign redirect_target = redirect_pc & ~PC_BITS'(3);

   assign imem_addr = pc;
   assign imem_req  = !rst && (state != S_ISSUE);

   always_comb begin
      d_rs1     = '0;
      d_rs2     = '0;
      d_ws      = '0;
      d_op      = ALU_ADD;
      d_imm_e   = 1'b0;
      d_imm_d   = '0;
      d_re      = 1'b0;
      d_we      = 1'b0;
      d_illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            d_rs1 = f_rs1;
            d_rs2 = f_rs2;
            d_ws  = f_rd;
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000:  d_op = ALU_ADD;
                  3'b111:  d_op = ALU_AND;
                  3'b110:  d_op = ALU_OR;
                  3'b100:  d_op = ALU_XOR;
                  3'b010:  d_op = ALU_SLT;
                  default: d_illegal = 1'b1;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               d_op = ALU_SUB;
            end else begin
               d_illegal = 1'b1;
            end
         end
         OPC_OPIMM: begin
            d_rs1   = f_rs1;
            d_ws    = f_rd;
            d_imm_e = 1'b1;
            d_imm_d = imm_i;
            case (funct3)
               3'b000:  d_op = ALU_ADD;
               3'b111:  d_op = ALU_AND;
               3'b110:  d_op = ALU_OR;
               3'b100:  d_op = ALU_XOR;
               3'b010:  d_op = ALU_SLT;
               default: d_illegal = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            if (funct3 == 3'b010) begin
               d_rs1   = f_rs1;
               d_ws    = f_rd;
               d_imm_e = 1'b1;
               d_imm_d = imm_i;
               d_re    = 1'b1;
            end else begin
               d_illegal = 1'b1;
            end
         end
         OPC_STORE: begin
            if (funct3 == 3'b010) begin
               d_rs1   = f_rs1;
               d_rs2   = f_rs2;
               d_imm_e = 1'b1;
               d_imm_d = imm_s;
               d_we    = 1'b1;
            end else begin
               d_illegal = 1'b1;
            end
         end
         default: d_illegal = 1'b1;
      endcase
      // Unsupported words still retire, but as a harmless NOP.
      if (d_illegal) begin
         d_rs1   = '0;
         d_rs2   = '0;
         d_ws    = '0;
         d_op    = ALU_ADD;
         d_imm_e = 1'b0;
         d_imm_d = '0;
         d_re    = 1'b0;
         d_we    = 1'b0;
      end
   end

   // Redirect in WAIT keeps the request open but marks the pending word for disposal.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_FETCH;
         pc      <= RESET_PC;
         discard <= 1'b0;
         valid   <= 1'b0;
         rs1     <= '0;
         rs2     <= '0;
         ws      <= '0;
         op      <= '0;
         imm_e   <= 1'b0;
         imm_d   <= '0;
         mem_re  <= 1'b0;
         mem_we  <= 1'b0;
         illegal <= 1'b0;
      end else if (redirect) begin
         pc    <= redirect_target;
         valid <= 1'b0;
         if (state == S_WAIT && !imem_ack) begin
            state   <= S_WAIT;
            discard <= 1'b1;
         end else begin
            state   <= S_FETCH;
            discard <= 1'b0;
         end
      end else begin
         case (state)
            S_FETCH: state <= S_WAIT;
            S_WAIT: begin
               if (imem_ack) begin
                  if (discard) begin
                     discard <= 1'b0;
                     state   <= S_FETCH;
                  end else begin
                     rs1     <= d_rs1;
                     rs2     <= d_rs2;
                     ws      <= d_ws;
                     op      <= d_op;
                     imm_e   <= d_imm_e;
                     imm_d   <= d_imm_d;
                     mem_re  <= d_re;
                     mem_we  <= d_we;
                     illegal <= d_illegal;
                     valid   <= 1'b1;
                     state   <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (!stall) begin
                  valid <= 1'b0;
                  pc    <= pc + PC_BITS'(4);
                  state <= S_FETCH;
               end
            end
            default: state <= S_FETCH;
         endcase
      end
   end

`ifdef FETCH_DECODE_COUNT_EN
   // A redirect out of ISSUE discards the word, so it does not count as retired.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_cnt <= '0;
         stall_cnt   <= '0;
      end else if (state == S_ISSUE) begin
         if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end else if (!redirect) begin
            retired_cnt <= retired_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: table-driven, scoreboarded bench for fetch_decode (also exercises FETCH_DECODE_COUNT_EN when defined).
module tb_fetch_decode;

   typedef struct packed {
      logic [31:0] word;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  ws;
      logic [3:0]  op;
      logic        imm_e;
      logic [31:0] imm_d;
      logic        re;
      logic        we;
      logic        ill;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        valid;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  ws;
   logic [3:0]  op;
   logic        imm_e;
   logic [31:0] imm_d;
   logic        mem_re;
   logic        mem_we;
   logic        illegal;
`ifdef FETCH_DECODE_COUNT_EN
   logic [31:0] retired_cnt;
   logic [31:0] stall_cnt;
   logic [31:0] stall_base;
`endif

   int          total;
   int          bad;
   int          n_retired;
   logic [15:0] exp_pc;
   logic        prev_valid;
   vec_t        exp_q[$];
   vec_t        vecs[14];

   fetch_decode dut (
      .clk(clk),
      .rst(rst),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .valid(valid),
      .rs1(rs1),
      .rs2(rs2),
      .ws(ws),
      .op(op),
      .imm_e(imm_e),
      .imm_d(imm_d),
      .mem_re(mem_re),
      .mem_we(mem_we),
      .illegal(illegal)
`ifdef FETCH_DECODE_COUNT_EN
      ,
      .retired_cnt(retired_cnt),
      .stall_cnt(stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] w, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] wd, input logic [3:0] o, input logic ie,
                               input logic [31:0] id, input logic re, input logic we, input logic il);
      vec_t v;
      v.word = w; v.rs1 = r1; v.rs2 = r2; v.ws = wd; v.op = o;
      v.imm_e = ie; v.imm_d = id; v.re = re; v.we = we; v.ill = il;
      return v;
   endfunction

   // Scoreboard: each rising valid retires the oldest pushed expectation.
   initial begin
      vec_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_issue: got valid=1 word rs1=%0d ws=%0d, expected no issue", rs1, ws);
            end else begin
               e = exp_q.pop_front();
               checkOutput("rs1", rs1, e.rs1);
               checkOutput("rs2", rs2, e.rs2);
               checkOutput("ws", ws, e.ws);
               checkOutput("op", op, e.op);
               checkOutput("imm_e", imm_e, e.imm_e);
               checkOutput("imm_d", imm_d, e.imm_d);
               checkOutput("mem_re", mem_re, e.re);
               checkOutput("mem_we", mem_we, e.we);
               checkOutput("illegal", illegal, e.ill);
            end
         end
         prev_valid = valid;
      end
   end

   // Starts in a FETCH cycle (or waits for one), ends in the FETCH cycle after retirement.
   task automatic applyStimulus(input vec_t v, input int extra_wait, input int stall_n);
      for (int t = 0; t < 20 && !imem_req; t++) @(negedge clk);
      if (!imem_req) begin
         total++;
         bad++;
         $display("[TB] FAIL req_timeout: got imem_req=0, expected 1 within 20 cycles");
         return;
      end
      checkOutput("fetch_addr", imem_addr, exp_pc);
      @(negedge clk);
      for (int k = 0; k < extra_wait; k++) begin
         checkOutput("wait_addr", imem_addr, exp_pc);
         @(negedge clk);
      end
      exp_q.push_back(v);
      imem_rdata = v.word;
      imem_ack   = 1'b1;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      checkOutput("issue_req", imem_req, 1'b0);
      for (int k = 0; k < stall_n; k++) begin
         stall = 1'b1;
         @(negedge clk);
         checkOutput("stall_hold", {rs1, rs2, ws, op, imm_e, imm_d, mem_re, mem_we, illegal, valid},
                     {v.rs1, v.rs2, v.ws, v.op, v.imm_e, v.imm_d, v.re, v.we, v.ill, 1'b1});
         checkOutput("stall_req_pc", {imem_req, imem_addr}, {1'b0, exp_pc});
      end
      stall = 1'b0;
      @(negedge clk);
      exp_pc = exp_pc + 16'd4;
      n_retired++;
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 300000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t v;
      total = 0; bad = 0; n_retired = 0;
      exp_pc = 16'h0000;
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
      redirect = 1'b0; redirect_pc = '0;

      vecs[0]  = mk(32'h00500093, 5'd0,  5'd0, 5'd1,  4'b0001, 1'b1, 32'h00000005, 1'b0, 1'b0, 1'b0);
      vecs[1]  = mk(32'h40300233, 5'd0,  5'd3, 5'd4,  4'b0110, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0);
      vecs[2]  = mk(32'hFFC12283, 5'd2,  5'd0, 5'd5,  4'b0001, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0);
      vecs[3]  = mk(32'h00512423, 5'd2,  5'd5, 5'd0,  4'b0001, 1'b1, 32'h00000008, 1'b0, 1'b1, 1'b0);
      vecs[4]  = mk(32'hFFFFFFFF, 5'd0,  5'd0, 5'd0,  4'b0001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
      vecs[5]  = mk(32'h002081B3, 5'd1,  5'd2, 5'd3,  4'b0001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0);
      vecs[6]  = mk(32'h005373B3, 5'd6,  5'd5, 5'd7,  4'b0000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0);
      vecs[7]  = mk(32'h00A4E433, 5'd9,  5'd10, 5'd8, 4'b0010, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0);
      vecs[8]  = mk(32'h003140B3, 5'd2,  5'd3, 5'd1,  4'b0011, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0);
      vecs[9]  = mk(32'h0041A133, 5'd3,  5'd4, 5'd2,  4'b0111, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0);
      vecs[10] = mk(32'hFFF62593, 5'd12, 5'd0, 5'd11, 4'b0111, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      vecs[11] = mk(32'h8000F793, 5'd1,  5'd0, 5'd15, 4'b0000, 1'b1, 32'hFFFFF800, 1'b0, 1'b0, 1'b0);
      vecs[12] = mk(32'hFE112C23, 5'd2,  5'd1, 5'd0,  4'b0001, 1'b1, 32'hFFFFFFF8, 1'b0, 1'b1, 1'b0);
      vecs[13] = mk(32'h00109093, 5'd0,  5'd0, 5'd0,  4'b0001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_req", imem_req, 1'b0);
      checkOutput("reset_valid", valid, 1'b0);
      checkOutput("reset_illegal", illegal, 1'b0);
      checkOutput("reset_ctrl", {rs1, rs2, ws, op, imm_e, imm_d, mem_re, mem_we}, 64'd0);
      checkOutput("reset_addr", imem_addr, 16'h0000);
`ifdef FETCH_DECODE_COUNT_EN
      checkOutput("reset_counts", {retired_cnt, stall_cnt}, 64'd0);
`endif
      rst = 1'b0;
      #1;
      checkOutput("first_req", {imem_req, imem_addr}, {1'b1, 16'h0000});

      for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i % 3, 0);

      $display("[TB] stall hold sequence");
`ifdef FETCH_DECODE_COUNT_EN
      stall_base = stall_cnt;
`endif
      applyStimulus(vecs[1], 0, 3);
`ifdef FETCH_DECODE_COUNT_EN
      checkOutput("stall_cnt_delta", stall_cnt - stall_base, 32'd3);
`endif

      $display("[TB] ack outside WAIT is ignored");
      checkOutput("early_ack_addr", {imem_req, imem_addr}, {1'b1, exp_pc});
      imem_rdata = 32'hFFFFFFFF;
      imem_ack   = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      checkOutput("early_ack_valid", valid, 1'b0);
      exp_q.push_back(vecs[2]);
      imem_rdata = vecs[2].word;
      imem_ack   = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      exp_pc = exp_pc + 16'd4;
      n_retired++;

      $display("[TB] redirect while waiting");
      checkOutput("redir_fetch_addr", {imem_req, imem_addr}, {1'b1, exp_pc});
      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = 16'h0043;
      @(negedge clk);
      redirect = 1'b0;
      checkOutput("redir_wait_addr", {imem_req, imem_addr, valid}, {1'b1, 16'h0040, 1'b0});
      imem_rdata = vecs[0].word;
      imem_ack   = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      checkOutput("dropped_valid", valid, 1'b0);
      checkOutput("refetch_addr", {imem_req, imem_addr}, {1'b1, 16'h0040});
      exp_pc = 16'h0040;
      applyStimulus(vecs[3], 0, 0);

      $display("[TB] redirect beats stall, then PC wrap");
      @(negedge clk);
      exp_q.push_back(vecs[5]);
      imem_rdata = vecs[5].word;
      imem_ack   = 1'b1;
      @(negedge clk);
      imem_ack    = 1'b0;
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 16'hFFFE;
      @(negedge clk);
      stall    = 1'b0;
      redirect = 1'b0;
      checkOutput("redir_issue", {valid, imem_req, imem_addr}, {1'b0, 1'b1, 16'hFFFC});
      exp_pc = 16'hFFFC;
      applyStimulus(vecs[4], 1, 0);
      applyStimulus(vecs[6], 0, 0);

      v = vecs[10];
      applyStimulus(v, 2, 1);

      checkOutput("queue_empty", exp_q.size(), 0);
`ifdef FETCH_DECODE_COUNT_EN
      checkOutput("retired_cnt", retired_cnt, n_retired);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
